// File: rtl/tt_bin_clock_v2.sv
// Binary hh:mm:ss clock with debounced-free synchronized set buttons and 12/24-hour display.
// Optional alarm (latch + compare) is built in when TT_BIN_CLOCK_ALARM_EN is defined.
module tt_bin_clock_v2 #(
  parameter int unsigned CLK_DIV = 10000000,
  parameter bit          FMT_24H = 1'b0
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [1:0] hour_id,
  input  logic [1:0] minute_id,
  input  logic       meridiem_id,
  input  logic       run_i,
`ifdef TT_BIN_CLOCK_ALARM_EN
  input  logic       alarm_set_i,
  input  logic       alarm_arm_i,
  output logic       alarm_o,
`endif
  output logic [4:0] hour_o,
  output logic [5:0] minute_o,
  output logic [5:0] second_o,
  output logic       meridiem_o,
  output logic       tick_o
);

  localparam int unsigned   PW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(CLK_DIV - 1);
  localparam logic [4:0]    H_MIN  = FMT_24H ? 5'd0  : 5'd1;
  localparam logic [4:0]    H_MAX  = FMT_24H ? 5'd23 : 5'd12;
  localparam logic [4:0]    H_RST  = FMT_24H ? 5'd0  : 5'd12;

`ifdef TT_BIN_CLOCK_ALARM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif

  logic [NB-1:0] btn_raw;
  logic [NB-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, armed_q, armed_d;
  logic [NB-1:0] evt;
  logic [1:0]    fill_q, fill_d;

`ifdef TT_BIN_CLOCK_ALARM_EN
  assign btn_raw = {alarm_set_i, hour_id, minute_id, meridiem_id};
`else
  assign btn_raw = {hour_id, minute_id, meridiem_id};
`endif

  // A button must be seen released after reset before it can fire, so a
  // press held through reset never produces an event.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    armed_d = armed_q | ({NB{fill_q == 2'd2}} & ~sync2_q);
  end

  assign evt = sync2_q & ~prev_q & armed_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      armed_q <= '0;
      fill_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      fill_q  <= fill_d;
    end
  end

  logic          hr_inc, hr_dec, mn_inc, mn_dec, mer_ev, hr_ev, mn_ev, any_ev, tick;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic [4:0]    hour_q, hour_d, h_adj;
  logic          mer_q, mer_d;

  assign hr_inc = evt[4];
  assign hr_dec = evt[3];
  assign mn_inc = evt[2];
  assign mn_dec = evt[1];
  assign mer_ev = evt[0];
  assign hr_ev  = hr_inc ^ hr_dec;
  assign mn_ev  = mn_inc ^ mn_dec;
  assign any_ev = |evt[4:0];
  assign tick   = run_i && (presc_q == PRE_TC);

  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    mer_d   = mer_q;
    h_adj   = hour_q;

    if (run_i) presc_d = tick ? '0 : presc_q + PW'(1);

    // Manual events win over a coincident tick; the tick still pulses.
    if (tick && !any_ev) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d  = 6'd0;
          hour_d = (hour_q == H_MAX) ? H_MIN : hour_q + 5'd1;
          if (!FMT_24H && hour_q == 5'd11) mer_d = ~mer_q;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    if (mn_ev) begin
      if (mn_inc) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      else        min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
      sec_d   = 6'd0;
      presc_d = '0;
    end

    if (hr_ev) begin
      if (hr_inc) h_adj = (hour_q == H_MAX) ? H_MIN : hour_q + 5'd1;
      else        h_adj = (hour_q == H_MIN) ? H_MAX : hour_q - 5'd1;
    end
    if (mer_ev) begin
      if (FMT_24H) h_adj = (h_adj >= 5'd12) ? h_adj - 5'd12 : h_adj + 5'd12;
      else         mer_d = ~mer_q;
    end
    if (hr_ev || mer_ev) hour_d = h_adj;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      presc_q <= '0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hour_q  <= H_RST;
      mer_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      mer_q   <= mer_d;
    end
  end

  assign hour_o     = hour_q;
  assign minute_o   = min_q;
  assign second_o   = sec_q;
  assign meridiem_o = FMT_24H ? (hour_q >= 5'd12) : mer_q;
  assign tick_o     = tick;

`ifdef TT_BIN_CLOCK_ALARM_EN
  logic [4:0] al_hour_q, al_hour_d;
  logic [5:0] al_min_q, al_min_d;
  logic       al_mer_q, al_mer_d, arm1_q, arm1_d, arm2_q, arm2_d, alarm_q, alarm_d;

  always_comb begin
    al_hour_d = al_hour_q;
    al_min_d  = al_min_q;
    al_mer_d  = al_mer_q;
    if (evt[5]) begin
      al_hour_d = hour_q;
      al_min_d  = min_q;
      al_mer_d  = meridiem_o;
    end
    arm1_d  = alarm_arm_i;
    arm2_d  = arm1_q;
    alarm_d = arm2_q && (hour_q == al_hour_q) && (min_q == al_min_q) &&
              (meridiem_o == al_mer_q);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      al_hour_q <= 5'd0;
      al_min_q  <= 6'd0;
      al_mer_q  <= 1'b0;
      arm1_q    <= 1'b0;
      arm2_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      al_hour_q <= al_hour_d;
      al_min_q  <= al_min_d;
      al_mer_q  <= al_mer_d;
      arm1_q    <= arm1_d;
      arm2_q    <= arm2_d;
      alarm_q   <= alarm_d;
    end
  end

  assign alarm_o = alarm_q;
`endif

endmodule

// File: doc/tt_bin_clock_v2.md
TT_BIN_CLOCK_V2 -- requirements
Module: tt_bin_clock_v2

Interface
REQ-001 SHALL have parameter CLK_DIV, default 10000000, clock cycles per one-second tick (legal range 2 to 2^24).
REQ-002 SHALL have parameter FMT_24H, default 0; 0 selects 12-hour display with meridiem, 1 selects 24-hour display.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port hour_id, input, 2, asynchronous buttons: bit1 increments hour, bit0 decrements hour.
REQ-006 SHALL have port minute_id, input, 2, asynchronous buttons: bit1 increments minute, bit0 decrements minute.
REQ-007 SHALL have port meridiem_id, input, 1, asynchronous toggle button.
REQ-008 SHALL have port run_i, input, 1, level; 1 lets time advance, 0 freezes the prescaler and seconds.
REQ-009 SHALL have port hour_o, output, 5, binary hour.
REQ-010 SHALL have port minute_o, output, 6, binary minute 0-59.
REQ-011 SHALL have port second_o, output, 6, binary second 0-59.
REQ-012 SHALL have port meridiem_o, output, 1, 0=AM, 1=PM.
REQ-013 SHALL have port tick_o, output, 1, one-cycle pulse on every seconds increment.

Function
REQ-014 SHALL pass every button through a 2-flop synchronizer plus rising-edge detector; one press yields one event, 3 cycles after the input edge.
REQ-015 SHALL count the prescaler 0..CLK_DIV-1 while run_i=1; terminal count wraps to 0, advances seconds, and pulses tick_o in the same cycle.
REQ-016 SHALL carry seconds 59->0 into minutes and minutes 59->0 into hours.
REQ-017 SHALL, when FMT_24H=0, count hours 1..12 with 12->1; a carry 11->12 toggles meridiem_o.
REQ-018 SHALL, when FMT_24H=1, count hours 0..23 with 23->0; meridiem_o = (hour_o >= 12).
REQ-019 SHALL make a minute increment/decrement event wrap 59<->0 without carry into hours, clear seconds to 0, and reload the prescaler to 0.
REQ-020 SHALL make an hour event wrap within its legal range with no meridiem change in 12-hour mode.
REQ-021 SHALL, on a meridiem event, toggle meridiem_o in 12-hour mode, or add 12 modulo 24 to the hour in 24-hour mode.
REQ-022 SHALL ignore a field's events when its increment and decrement events occur in the same cycle.
REQ-023 SHALL give manual events priority: a tick in the same cycle as any event does not advance time, though tick_o still pulses.
REQ-024 SHALL apply hour, minute and meridiem events together when they coincide in one cycle.
REQ-025 SHALL keep adjustments active while run_i=0.

Reset
REQ-026 SHALL, while rstn_i=0, hold hour_o at 12 (FMT_24H=0) or 0 (FMT_24H=1), with minute_o=0, second_o=0, meridiem_o=0, tick_o=0, prescaler=0, and synchronizer flops at 0.
REQ-027 SHALL resume counting on the first clock edge after rstn_i deasserts, including when reset is asserted mid-count or mid-press; a button held through reset produces no event.

Configuration
REQ-028 SHALL, with macro TT_BIN_CLOCK_ALARM_EN defined, add ports alarm_set_i (input, 1, button), alarm_arm_i (input, 1, level) and alarm_o (output, 1).
REQ-029 SHALL, with TT_BIN_CLOCK_ALARM_EN defined, latch the current hour, minute and meridiem into alarm registers on each synchronized alarm_set_i edge.
REQ-030 SHALL, with TT_BIN_CLOCK_ALARM_EN defined, drive alarm_o=1 while alarm_arm_i=1 and hour, minute and meridiem match the alarm registers; alarm registers and alarm_o reset to 0.
REQ-031 SHALL, without TT_BIN_CLOCK_ALARM_EN, omit the alarm ports and logic entirely.

Verification
REQ-032 SHALL verify rollover: CLK_DIV=4, FMT_24H=0, preset 11:59:59 AM, run_i=1 -> after 4 cycles 12:00:00 with meridiem_o=1 and one tick_o pulse.
REQ-033 SHALL verify 24-hour wrap: FMT_24H=1, preset 23:59:59 -> next tick gives 00:00:00 with meridiem_o=0.
REQ-034 SHALL verify minute adjust: minute_id[0] pulse at 10:00:37 -> 10:59:00 after 3 cycles, hour unchanged, prescaler restarted.
REQ-035 SHALL verify collisions: an hour_id[1] event coinciding with a tick at 3:15:20 -> 4:15:20, tick_o=1, seconds not advanced; hour_id=2'b11 together -> no change.
REQ-036 SHALL verify reset: rstn_i low mid-count at 7:42:10 PM -> immediately 12:00:00 AM, tick_o=0; a button held through deassertion -> no event.
REQ-037 SHALL verify the alarm (macro defined): set at 6:30 AM, armed, clock advanced to 6:30 -> alarm_o=1 for the whole minute, 0 at 6:31 or when alarm_arm_i=0.
